tls_phase_monitor: RTL and testbench

- Observer block at the lamp side of the traffic-light controller.
- Samples the Gout/Yout/Rout lamp lines plus the controller's Stop/Jump/Set controls and reconstructs each phase length in cycles.
- Checks lengths against the programmed durations and flags illegal sequences or lamp combinations.
- Used as an on-chip self-check and as the bench scoreboard for the light controller.

---
 rtl/tls_phase_monitor.sv | 182 ++++++++++++++++++
 tb/tb_tls_phase_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tls_phase_monitor.sv
// Lamp-side observer for the traffic-light controller.
// Rebuilds phase lengths from the lamps and flags length, order and lamp faults.
module tls_phase_monitor #(
    parameter int CW = 4,
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Set,
    input  logic          Stop,
    input  logic          Jump,
    input  logic [CW-1:0] Gexp,
    input  logic [CW-1:0] Yexp,
    input  logic [CW-1:0] Rexp,
    input  logic          Glamp,
    input  logic          Ylamp,
    input  logic          Rlamp,
    output logic [SW-1:0] Gmeas,
    output logic [SW-1:0] Ymeas,
    output logic [SW-1:0] Rmeas,
    output logic          meas_valid,
    output logic          err_len,
    output logic          err_seq,
    output logic          err_lamp
);

    typedef enum logic [2:0] {
        IDLE,
        GREEN,
        YELLOW,
        RED,
        FAULT
    } state_t;

    state_t        state, state_n;
    logic [SW-1:0] count, count_n;
    logic [CW-1:0] gexp_q, yexp_q, rexp_q;
    logic [CW-1:0] gexp_n, yexp_n, rexp_n;
    logic          jump_q, jump_n;
    logic [SW-1:0] gmeas_n, ymeas_n, rmeas_n;
    logic          mv_n;
    logic          err_len_n, err_seq_n, err_lamp_n;

    logic [1:0]    lit_cnt;
    logic          lamp_ok;
    state_t        code;
    state_t        succ;
    logic [CW-1:0] exp_sel;
    logic [SW-1:0] exp_ext;
    logic [SW-1:0] cnt_inc;
    logic [SW-1:0] cnt_start;
    logic          jump_eff;
    logic          is_jump;
    logic          legal;

    // Decode the lamp lines into a single phase code and per-phase lookups.
    always_comb begin
        lit_cnt = {1'b0, Glamp} + {1'b0, Ylamp} + {1'b0, Rlamp};
        lamp_ok = (lit_cnt == 2'd1);
        code    = IDLE;
        if (lamp_ok) begin
            if (Glamp)      code = GREEN;
            else if (Ylamp) code = YELLOW;
            else            code = RED;
        end
        succ    = IDLE;
        exp_sel = '0;
        case (state)
            GREEN:  begin succ = YELLOW; exp_sel = gexp_q; end
            YELLOW: begin succ = RED;    exp_sel = yexp_q; end
            RED:    begin succ = GREEN;  exp_sel = rexp_q; end
            default: ;
        endcase
        exp_ext   = SW'(exp_sel);
        cnt_inc   = (count == '1) ? count : count + SW'(1);
        cnt_start = {{(SW-1){1'b0}}, ~Stop};
        jump_eff  = jump_q | Jump;
        is_jump   = jump_eff && (code == RED) && (state != RED);
        legal     = (code == succ) || is_jump;
    end

    // Next-state, counter, measurement and error update.
    always_comb begin
        state_n    = state;
        count_n    = count;
        gexp_n     = gexp_q;
        yexp_n     = yexp_q;
        rexp_n     = rexp_q;
        jump_n     = jump_q;
        gmeas_n    = Gmeas;
        ymeas_n    = Ymeas;
        rmeas_n    = Rmeas;
        mv_n       = 1'b0;
        err_len_n  = err_len;
        err_seq_n  = err_seq;
        err_lamp_n = err_lamp;
        if (Set) begin
            gexp_n     = Gexp;
            yexp_n     = Yexp;
            rexp_n     = Rexp;
            err_len_n  = 1'b0;
            err_seq_n  = 1'b0;
            err_lamp_n = 1'b0;
            count_n    = '0;
            jump_n     = 1'b0;
            state_n    = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    jump_n = jump_eff;
                    if (lamp_ok) begin
                        state_n = code;
                        count_n = cnt_start;
                        if (code == RED) jump_n = 1'b0;
                    end
                end
                GREEN, YELLOW, RED: begin
                    if (!lamp_ok) begin
                        err_lamp_n = 1'b1;
                        state_n    = FAULT;
                    end else if (code == state) begin
                        jump_n = jump_eff;
                        if (!Stop) begin
                            count_n = cnt_inc;
                            if (exp_sel != '0 && cnt_inc == exp_ext + SW'(1))
                                err_len_n = 1'b1;
                        end
                    end else if (legal) begin
                        if (state == GREEN)       gmeas_n = count;
                        else if (state == YELLOW) ymeas_n = count;
                        else                      rmeas_n = count;
                        mv_n = 1'b1;
                        if (!is_jump && exp_sel != '0 && count != exp_ext)
                            err_len_n = 1'b1;
                        state_n = code;
                        count_n = cnt_start;
                        jump_n  = (code == RED) ? 1'b0 : jump_eff;
                    end else begin
                        err_seq_n = 1'b1;
                        state_n   = FAULT;
                    end
                end
                FAULT: ;
                default: state_n = IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            gexp_q     <= '0;
            yexp_q     <= '0;
            rexp_q     <= '0;
            jump_q     <= 1'b0;
            Gmeas      <= '0;
            Ymeas      <= '0;
            Rmeas      <= '0;
            meas_valid <= 1'b0;
            err_len    <= 1'b0;
            err_seq    <= 1'b0;
            err_lamp   <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            gexp_q     <= gexp_n;
            yexp_q     <= yexp_n;
            rexp_q     <= rexp_n;
            jump_q     <= jump_n;
            Gmeas      <= gmeas_n;
            Ymeas      <= ymeas_n;
            Rmeas      <= rmeas_n;
            meas_valid <= mv_n;
            err_len    <= err_len_n;
            err_seq    <= err_seq_n;
            err_lamp   <= err_lamp_n;
        end
    end

endmodule

// File: tb/tb_tls_phase_monitor.sv
// Directed bench for tls_phase_monitor.
// Inputs change on negedge, outputs are checked on the following negedge.
module tb_tls_phase_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Set = 1'b0;
    logic       Stop = 1'b0;
    logic       Jump = 1'b0;
    logic [3:0] Gexp = '0;
    logic [3:0] Yexp = '0;
    logic [3:0] Rexp = '0;
    logic       Glamp = 1'b0;
    logic       Ylamp = 1'b0;
    logic       Rlamp = 1'b0;
    logic [4:0] Gmeas;
    logic [4:0] Ymeas;
    logic [4:0] Rmeas;
    logic       meas_valid;
    logic       err_len;
    logic       err_seq;
    logic       err_lamp;

    int pass_cnt = 0;
    int total_cnt = 0;
    int mvc = 0;

    tls_phase_monitor #(.CW(4), .SW(5)) dut (
        .clk(clk), .reset(reset), .Set(Set), .Stop(Stop), .Jump(Jump),
        .Gexp(Gexp), .Yexp(Yexp), .Rexp(Rexp),
        .Glamp(Glamp), .Ylamp(Ylamp), .Rlamp(Rlamp),
        .Gmeas(Gmeas), .Ymeas(Ymeas), .Rmeas(Rmeas),
        .meas_valid(meas_valid), .err_len(err_len),
        .err_seq(err_seq), .err_lamp(err_lamp)
    );

    always #5 clk = ~clk;

    task automatic step(input logic g, input logic y, input logic r,
                        input logic st = 1'b0, input logic jp = 1'b0);
        Glamp = g; Ylamp = y; Rlamp = r;
        Stop = st; Jump = jp; Set = 1'b0;
        @(negedge clk);
        Jump = 1'b0; Stop = 1'b0;
    endtask

    task automatic run(input logic g, input logic y, input logic r,
                       input int n, input logic st = 1'b0);
        for (int i = 0; i < n; i++) begin
            step(g, y, r, st);
            mvc += int'(meas_valid);
        end
    endtask

    task automatic do_set(input logic [3:0] g, input logic [3:0] y, input logic [3:0] r);
        Gexp = g; Yexp = y; Rexp = r;
        Glamp = 0; Ylamp = 0; Rlamp = 0;
        Set = 1'b1;
        @(negedge clk);
        Set = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_cnt++;
        if ({Gmeas, Ymeas, Rmeas, meas_valid, err_len, err_seq, err_lamp} !== 19'd0)
            $display("FAIL reset_outputs got=%h want=0",
                {Gmeas, Ymeas, Rmeas, meas_valid, err_len, err_seq, err_lamp});
        else pass_cnt++;
        reset = 1'b0;
        run(0, 0, 0, 3);
        total_cnt++;
        if ({meas_valid, err_len, err_seq, err_lamp} !== 4'd0)
            $display("FAIL idle_no_lamp got=%b want=0000",
                {meas_valid, err_len, err_seq, err_lamp});
        else pass_cnt++;
    endtask

    task automatic test_normal();
        do_set(3, 2, 4);
        mvc = 0;
        run(1, 0, 0, 3);
        step(0, 1, 0);
        mvc += int'(meas_valid);
        total_cnt++;
        if ({meas_valid, Gmeas} !== {1'b1, 5'd3})
            $display("FAIL normal_first_g got=%b/%0d want=1/3", meas_valid, Gmeas);
        else pass_cnt++;
        run(0, 1, 0, 1);
        run(0, 0, 1, 4);
        run(1, 0, 0, 3);
        run(0, 1, 0, 2);
        run(0, 0, 1, 4);
        run(1, 0, 0, 1);
        total_cnt++;
        if ({Gmeas, Ymeas, Rmeas} !== {5'd3, 5'd2, 5'd4})
            $display("FAIL normal_meas got=%0d/%0d/%0d want=3/2/4", Gmeas, Ymeas, Rmeas);
        else pass_cnt++;
        total_cnt++;
        if (mvc !== 6)
            $display("FAIL normal_pulses got=%0d want=6", mvc);
        else pass_cnt++;
        total_cnt++;
        if ({err_len, err_seq, err_lamp} !== 3'b000)
            $display("FAIL normal_errs got=%b want=000", {err_len, err_seq, err_lamp});
        else pass_cnt++;
    endtask

    task automatic test_stop();
        do_set(3, 2, 4);
        run(1, 0, 0, 2);
        run(1, 0, 0, 5, 1'b1);
        run(1, 0, 0, 1);
        step(0, 1, 0);
        total_cnt++;
        if ({meas_valid, Gmeas, err_len} !== {1'b1, 5'd3, 1'b0})
            $display("FAIL stop_hold got=%b/%0d/%b want=1/3/0", meas_valid, Gmeas, err_len);
        else pass_cnt++;
    endtask

    task automatic test_jump();
        do_set(3, 2, 4);
        run(1, 0, 0, 1);
        step(0, 0, 1, 1'b0, 1'b1);
        total_cnt++;
        if ({meas_valid, Gmeas, err_seq, err_len} !== {1'b1, 5'd1, 2'b00})
            $display("FAIL jump_trunc got=%b/%0d/%b/%b want=1/1/0/0",
                meas_valid, Gmeas, err_seq, err_len);
        else pass_cnt++;
        run(0, 0, 1, 3);
        step(1, 0, 0);
        total_cnt++;
        if ({Rmeas, err_len, err_seq} !== {5'd4, 2'b00})
            $display("FAIL jump_red got=%0d/%b/%b want=4/0/0", Rmeas, err_len, err_seq);
        else pass_cnt++;
    endtask

    task automatic test_len_mismatch();
        do_set(3, 2, 4);
        run(1, 0, 0, 3);
        run(0, 1, 0, 2);
        total_cnt++;
        if (err_len !== 1'b0)
            $display("FAIL len_y2 got=%b want=0", err_len);
        else pass_cnt++;
        run(0, 1, 0, 1);
        total_cnt++;
        if (err_len !== 1'b1)
            $display("FAIL len_y3 got=%b want=1", err_len);
        else pass_cnt++;
        run(0, 1, 0, 1);
        step(0, 0, 1);
        total_cnt++;
        if ({Ymeas, err_len} !== {5'd4, 1'b1})
            $display("FAIL len_ymeas got=%0d/%b want=4/1", Ymeas, err_len);
        else pass_cnt++;
        run(0, 0, 1, 3);
        run(1, 0, 0, 1);
        total_cnt++;
        if ({Rmeas, err_len} !== {5'd4, 1'b1})
            $display("FAIL len_sticky got=%0d/%b want=4/1", Rmeas, err_len);
        else pass_cnt++;
        do_set(3, 2, 4);
        total_cnt++;
        if (err_len !== 1'b0)
            $display("FAIL len_clear got=%b want=0", err_len);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        do_set(3, 2, 4);
        run(1, 0, 0, 2);
        step(0, 0, 1);
        total_cnt++;
        if ({err_seq, meas_valid} !== 2'b10)
            $display("FAIL seq_g_to_r got=%b want=10", {err_seq, meas_valid});
        else pass_cnt++;
        mvc = 0;
        run(0, 1, 0, 1);
        run(0, 0, 1, 1);
        run(1, 0, 0, 2);
        total_cnt++;
        if ({Gmeas, Ymeas, Rmeas, 27'(mvc), err_len} !== {5'd3, 5'd4, 5'd4, 27'd0, 1'b0})
            $display("FAIL fault_frozen got=%0d/%0d/%0d pulses=%0d len=%b want=3/4/4 0 0",
                Gmeas, Ymeas, Rmeas, mvc, err_len);
        else pass_cnt++;
        do_set(3, 2, 4);
        run(1, 0, 0, 1);
        step(1, 1, 0);
        total_cnt++;
        if ({err_lamp, err_seq} !== 2'b10)
            $display("FAIL bad_lamp got=%b want=10", {err_lamp, err_seq});
        else pass_cnt++;
    endtask

    task automatic test_set_priority();
        do_set(3, 2, 4);
        run(1, 0, 0, 2);
        Gexp = 3; Yexp = 2; Rexp = 4;
        Glamp = 0; Ylamp = 1; Rlamp = 0;
        Set = 1'b1;
        @(negedge clk);
        Set = 1'b0;
        total_cnt++;
        if ({meas_valid, Gmeas, err_lamp} !== {1'b0, 5'd3, 1'b0})
            $display("FAIL set_wins got=%b/%0d/%b want=0/3/0", meas_valid, Gmeas, err_lamp);
        else pass_cnt++;
        run(0, 1, 0, 2);
        step(0, 0, 1);
        total_cnt++;
        if ({meas_valid, Ymeas, err_len, err_seq} !== {1'b1, 5'd2, 2'b00})
            $display("FAIL idle_entry got=%b/%0d/%b/%b want=1/2/0/0",
                meas_valid, Ymeas, err_len, err_seq);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_set(3, 2, 4);
        run(1, 0, 0, 3);
        run(0, 1, 0, 2);
        run(0, 0, 1, 2);
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if ({Gmeas, Ymeas, Rmeas, meas_valid, err_len, err_seq, err_lamp} !== 19'd0)
            $display("FAIL reset_mid got=%h want=0",
                {Gmeas, Ymeas, Rmeas, meas_valid, err_len, err_seq, err_lamp});
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        run(1, 0, 0, 5);
        step(0, 1, 0);
        total_cnt++;
        if ({meas_valid, Gmeas, err_len} !== {1'b1, 5'd5, 1'b0})
            $display("FAIL after_reset got=%b/%0d/%b want=1/5/0", meas_valid, Gmeas, err_len);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_stop();
        test_jump();
        test_len_mismatch();
        test_illegal();
        test_set_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
